// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stage register and its optional stats block.
package pipe_pkg;

  typedef enum logic [1:0] {EMPTY, HALF, FULL} pipe_state_t;

  localparam logic [31:0] PIPE_NOP    = 32'h0;
  localparam int          PIPE_STAT_W = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [PIPE_STAT_W-1:0] sat_inc(input logic [PIPE_STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pipe_stage_stats.sv
// Saturating stall/flush event counters for one pipeline stage boundary.
module pipe_stage_stats
  import pipe_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   out_valid,
  input  logic                   out_ready,
  input  logic                   flush,
  input  logic                   busy,
  output logic [PIPE_STAT_W-1:0] stall_cnt,
  output logic [PIPE_STAT_W-1:0] flush_cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready) stall_cnt <= sat_inc(stall_cnt);
      if (flush && busy)           flush_cnt <= sat_inc(flush_cnt);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffered pipeline register with registered in_ready and synchronous flush.
// Define PIPE_STAGE_STATS_EN to add saturating stall_cnt/flush_cnt outputs.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                 INSTR_W   = 32,
  parameter int                 ADDR_W    = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(PIPE_NOP)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INSTR_W-1:0]     in_instr,
  input  logic [ADDR_W-1:0]      in_pcp4,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_W-1:0]     out_instr,
  output logic [ADDR_W-1:0]      out_pcp4
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [PIPE_STAT_W-1:0] stall_cnt,
  output logic [PIPE_STAT_W-1:0] flush_cnt
`endif
);

  pipe_state_t        state, state_nxt;
  logic [INSTR_W-1:0] main_instr, skid_instr;
  logic [ADDR_W-1:0]  main_pcp4, skid_pcp4;
  logic               accept, send;
  logic               ld_main_in, ld_main_skid, ld_skid, clr_main;

  assign accept    = in_valid & in_ready;
  assign send      = out_valid & out_ready;
  assign out_valid = (state != EMPTY);
  assign out_instr = main_instr;
  assign out_pcp4  = main_pcp4;

  always_comb begin
    state_nxt    = state;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    clr_main     = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
      clr_main  = 1'b1;
    end else begin
      unique case (state)
        EMPTY: if (accept) begin
          ld_main_in = 1'b1;
          state_nxt  = HALF;
        end
        HALF: begin
          if (accept && send) ld_main_in = 1'b1;
          else if (accept) begin
            ld_skid   = 1'b1;
            state_nxt = FULL;
          end else if (send) begin
            clr_main  = 1'b1;
            state_nxt = EMPTY;
          end
        end
        FULL: if (send) begin
          ld_main_skid = 1'b1;
          state_nxt    = HALF;
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Main is parked at NOP/0 whenever empty so outputs need no muxing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      in_ready   <= 1'b1;
      main_instr <= NOP_INSTR;
      main_pcp4  <= '0;
      skid_instr <= '0;
      skid_pcp4  <= '0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != FULL);
      if (clr_main) begin
        main_instr <= NOP_INSTR;
        main_pcp4  <= '0;
      end else if (ld_main_in) begin
        main_instr <= in_instr;
        main_pcp4  <= in_pcp4;
      end else if (ld_main_skid) begin
        main_instr <= skid_instr;
        main_pcp4  <= skid_pcp4;
      end
      if (flush) begin
        skid_instr <= '0;
        skid_pcp4  <= '0;
      end else if (ld_skid) begin
        skid_instr <= in_instr;
        skid_pcp4  <= in_pcp4;
      end
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  pipe_stage_stats u_stats (
    .clk       (clk),
    .rst_n     (rst_n),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .flush     (flush),
    .busy      (state != EMPTY),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: driver pushes expected beats, negedge monitor pops and compares.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [31:0] in_instr = '0, in_pcp4 = '0;
  logic        in_ready, out_valid;
  logic [31:0] out_instr, out_pcp4;
`ifdef PIPE_STAGE_STATS_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  pipe_stage_reg #(.INSTR_W(32), .ADDR_W(32), .NOP_INSTR(NOP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pcp4   (in_pcp4),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pcp4  (out_pcp4)
`ifdef PIPE_STAGE_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [31:0] instr; logic [31:0] pcp4;} beat_t;

  // Reference model: the beats the stage currently holds, oldest first, capacity two.
  beat_t q[$];
  int    checks = 0, errors = 0;
  bit    exp_ready = 1'b1, exp_valid = 1'b0, mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; the accepted, unflushed beat becomes an expected response.
  task automatic drive(input bit iv, input logic [31:0] ins, input logic [31:0] pc,
                       input bit ordy, input bit fl);
    @(posedge clk); #1;
    exp_ready = (q.size() < 2);
    exp_valid = (q.size() != 0);
    in_valid  = iv;
    in_instr  = ins;
    in_pcp4   = pc;
    out_ready = ordy;
    flush     = fl;
    if (iv && exp_ready && !fl) q.push_back(beat_t'{ins, pc});
    mon_en = 1'b1;
  endtask

  task automatic idle(input bit ordy);
    drive(1'b0, 32'hx, 32'hx, ordy, 1'b0);
  endtask

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      check("out_valid", 32'(out_valid), 32'(exp_valid));
      check("in_ready", 32'(in_ready), 32'(exp_ready));
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %h expected none (t=%0t)", out_instr, $time);
        end else begin
          beat_t b;
          b = q.pop_front();
          check("out_instr", out_instr, b.instr);
          check("out_pcp4", out_pcp4, b.pcp4);
        end
      end else if (!out_valid) begin
        check("bubble_instr", out_instr, NOP);
        check("bubble_pcp4", out_pcp4, 32'h0);
      end
      if (flush) q.delete();
    end
  end

  initial begin
    #12;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_out_instr", out_instr, NOP);
    check("rst_out_pcp4", out_pcp4, 32'h0);
    @(negedge clk) rst_n = 1'b1;

    // Streaming with no backpressure.
    drive(1'b1, 32'h1111_1111, 32'h0000_0004, 1'b1, 1'b0);
    drive(1'b1, 32'h2222_2222, 32'h0000_0008, 1'b1, 1'b0);
    drive(1'b1, 32'h3333_3333, 32'h0000_000C, 1'b1, 1'b0);
    repeat (2) idle(1'b1);

    // Fill to FULL, an ignored out-of-protocol beat, then drain in order.
    drive(1'b1, 32'hAAAA_0001, 32'h0000_0100, 1'b0, 1'b0);
    drive(1'b1, 32'hBBBB_0002, 32'h0000_0104, 1'b0, 1'b0);
    drive(1'b1, 32'hCCCC_0003, 32'h0000_0108, 1'b0, 1'b0);
    idle(1'b0);
    repeat (3) idle(1'b1);

    // Flush while FULL with a coincident upstream beat.
    drive(1'b1, 32'hAAAA_1001, 32'h0000_0200, 1'b0, 1'b0);
    drive(1'b1, 32'hBBBB_1002, 32'h0000_0204, 1'b0, 1'b0);
    idle(1'b0);
    drive(1'b1, 32'hEEEE_1003, 32'h0000_0208, 1'b0, 1'b1);
    repeat (3) idle(1'b1);

    // Flush coincident with a send: the beat is still delivered once.
    drive(1'b1, 32'hDEAD_BEEF, 32'h0000_0300, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    repeat (2) idle(1'b1);

    // Randomised traffic with occasional flushes.
    for (int i = 0; i < 3000; i++)
      drive($urandom_range(0, 3) != 0, $urandom, $urandom,
            $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
    repeat (3) idle(1'b1);

    // Asynchronous reset mid-cycle while FULL.
    drive(1'b1, 32'h7777_0001, 32'h0000_0400, 1'b0, 1'b0);
    drive(1'b1, 32'h7777_0002, 32'h0000_0404, 1'b0, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("full_before_rst_in_ready", 32'(in_ready), 32'h0);
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    q.delete();
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'h0);
    check("async_rst_in_ready", 32'(in_ready), 32'h1);
    check("async_rst_out_instr", out_instr, NOP);
    check("async_rst_out_pcp4", out_pcp4, 32'h0);
    @(negedge clk) rst_n = 1'b1;

`ifdef PIPE_STAGE_STATS_EN
    check("stats_rst_stall", 32'(stall_cnt), 32'h0);
    check("stats_rst_flush", 32'(flush_cnt), 32'h0);
    drive(1'b1, 32'h5151_5151, 32'h0000_0500, 1'b0, 1'b0);
    repeat (5) idle(1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    idle(1'b1);
    check("stats_stall_5", 32'(stall_cnt), 32'h5);
    check("stats_flush_1", 32'(flush_cnt), 32'h1);
    drive(1'b1, 32'h6161_6161, 32'h0000_0504, 1'b0, 1'b0);
    repeat (70000) idle(1'b0);
    idle(1'b1);
    check("stats_stall_sat", 32'(stall_cnt), 32'hFFFF);
    idle(1'b1);
`endif

    // First beat after reset release passes normally.
    drive(1'b1, 32'h5555_5555, 32'h0000_0600, 1'b1, 1'b0);
    repeat (3) idle(1'b1);
    check("drained", 32'(q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
